// File: rtl/float_add_sequencer_pkg.sv
// Shared float types, constants and the issue-sequencer state encoding.
// Special-operand helpers serve the FP_SPECIAL_BYPASS_EN build of float_add_sequencer.
package float_add_sequencer_pkg;

    typedef logic [31:0] float;

    localparam float       QNAN        = 32'h7FC0_0000;
    localparam logic [7:0] EXP_SPECIAL = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } seq_state_t;

    function automatic logic is_special(input float a, input float b);
        return (a[30:23] == 8'h00) || (a[30:23] == EXP_SPECIAL) ||
               (b[30:23] == 8'h00) || (b[30:23] == EXP_SPECIAL);
    endfunction

    // Denormals (exp==0) are flushed to signed zero before the rules apply.
    function automatic float special_sum(input float a, input float b);
        logic a_inf, b_inf, a_nan, b_nan, a_zero, b_zero;
        a_inf  = (a[30:23] == EXP_SPECIAL) && (a[22:0] == '0);
        b_inf  = (b[30:23] == EXP_SPECIAL) && (b[22:0] == '0);
        a_nan  = (a[30:23] == EXP_SPECIAL) && (a[22:0] != '0);
        b_nan  = (b[30:23] == EXP_SPECIAL) && (b[22:0] != '0);
        a_zero = (a[30:23] == 8'h00);
        b_zero = (b[30:23] == 8'h00);
        if (a_nan || b_nan)            return QNAN;
        else if (a_inf && b_inf)       return (a[31] != b[31]) ? QNAN : a;
        else if (a_inf)                return a;
        else if (b_inf)                return b;
        else if (a_zero && b_zero)     return {a[31] & b[31], 31'h0};
        else if (a_zero)               return b;
        else                           return a;
    endfunction

endpackage

// File: rtl/float_pair_fifo.sv
// Operand-pair FIFO: 64-bit entries, power-of-two depth, registered full flag and count.
module float_pair_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     push_i,
    input  logic [63:0]              push_data_i,
    input  logic                     pop_i,
    output logic [63:0]              head_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [63:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          full_q;
    logic          push_ok, pop_ok;

    assign push_ok = push_i && !full_q;
    assign pop_ok  = pop_i && (count_q != '0);

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == (AW+1)'(DEPTH));
        end
    end

    always_ff @(posedge Clock) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = full_q;
    assign count_o = count_q;

endmodule

// File: rtl/float_add_sequencer.sv
// Issue stage in front of FloatAdder: queue pairs, issue one at a time, hold the sum.
// Optional macro FP_SPECIAL_BYPASS_EN resolves zero/Inf/NaN operands locally.
//
// state | meaning
// IDLE  | waiting for a queued pair; head latched into AddOp1/2 on exit
// ISSUE | AddInputValid pulse, head popped, watchdog loaded
// WAIT  | waiting for AddResultValid rising edge or watchdog expiry
// HOLD  | OutValid asserted until consumer takes the result
module float_add_sequencer
    import float_add_sequencer_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic [31:0]            InOp1,
    input  logic [31:0]            InOp2,
    input  logic                   InValid,
    output logic                   InReady,
    output logic [31:0]            AddOp1,
    output logic [31:0]            AddOp2,
    output logic                   AddInputValid,
    input  logic [31:0]            AddResult,
    input  logic                   AddResultValid,
    output logic [31:0]            OutResult,
    output logic                   OutError,
    output logic                   OutValid,
    input  logic                   OutReady,
    output logic [$clog2(DEPTH):0] Occupancy
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    seq_state_t    state_q, state_d;
    float          op1_q, op1_d, op2_q, op2_d;
    float          res_q, res_d;
    logic          err_q, err_d;
    logic [TW-1:0] wcnt_q, wcnt_d;
    logic          rv_q;
    logic          pop;
    logic [63:0]   head;
    logic          empty, full;

    float_pair_fifo #(.DEPTH(DEPTH)) u_fifo (
        .Clock       (Clock),
        .Reset       (Reset),
        .push_i      (InValid),
        .push_data_i ({InOp1, InOp2}),
        .pop_i       (pop),
        .head_o      (head),
        .empty_o     (empty),
        .full_o      (full),
        .count_o     (Occupancy)
    );

    always_comb begin
        state_d = state_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        res_d   = res_q;
        err_d   = err_q;
        wcnt_d  = wcnt_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
`ifdef FP_SPECIAL_BYPASS_EN
                    if (is_special(head[63:32], head[31:0])) begin
                        res_d   = special_sum(head[63:32], head[31:0]);
                        err_d   = 1'b0;
                        pop     = 1'b1;
                        state_d = HOLD;
                    end else
`endif
                    begin
                        op1_d   = head[63:32];
                        op2_d   = head[31:0];
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                pop     = 1'b1;
                wcnt_d  = TW'(TIMEOUT_CYCLES - 1);
                state_d = WAIT;
            end
            WAIT: begin
                // A level already high on entry is not a completion of this op.
                if (AddResultValid && !rv_q) begin
                    res_d   = AddResult;
                    err_d   = 1'b0;
                    state_d = HOLD;
                end else if (wcnt_q == '0) begin
                    res_d   = QNAN;
                    err_d   = 1'b1;
                    state_d = HOLD;
                end else begin
                    wcnt_d = wcnt_q - 1'b1;
                end
            end
            HOLD: begin
                if (OutReady) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            op1_q   <= '0;
            op2_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            wcnt_q  <= '0;
            rv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            res_q   <= res_d;
            err_q   <= err_d;
            wcnt_q  <= wcnt_d;
            rv_q    <= AddResultValid;
        end
    end

    assign InReady       = !full;
    assign AddOp1        = op1_q;
    assign AddOp2        = op2_q;
    assign AddInputValid = (state_q == ISSUE);
    assign OutResult     = res_q;
    assign OutError      = err_q;
    assign OutValid      = (state_q == HOLD);

endmodule

// File: tb/tb_float_add_sequencer.sv
// Scoreboard bench for float_add_sequencer with a behavioural FloatAdder stand-in.
// Expectations adapt to FP_SPECIAL_BYPASS_EN when the build defines it.
module tb_float_add_sequencer;

    typedef struct { logic [31:0] res; logic err; } exp_t;
    typedef struct { logic [31:0] a; logic [31:0] b; logic [31:0] ares; int dly; } iss_t;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [31:0] InOp1, InOp2;
    logic        InValid;
    logic        InReady;
    logic [31:0] AddOp1, AddOp2;
    logic        AddInputValid;
    logic [31:0] AddResult;
    logic        AddResultValid;
    logic [31:0] OutResult;
    logic        OutError;
    logic        OutValid;
    logic        OutReady;
    logic [2:0]  Occupancy;

    int   checks = 0;
    int   errors = 0;
    int   issue_cnt = 0;
    exp_t exp_q[$];
    iss_t iss_q[$];

    float_add_sequencer #(.DEPTH(4), .TIMEOUT_CYCLES(64)) dut (
        .Clock(Clock), .Reset(Reset), .InOp1(InOp1), .InOp2(InOp2),
        .InValid(InValid), .InReady(InReady), .AddOp1(AddOp1), .AddOp2(AddOp2),
        .AddInputValid(AddInputValid), .AddResult(AddResult),
        .AddResultValid(AddResultValid), .OutResult(OutResult), .OutError(OutError),
        .OutValid(OutValid), .OutReady(OutReady), .Occupancy(Occupancy)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic bit bypassed(input logic [31:0] a, input logic [31:0] b);
        bit r = 1'b0;
`ifdef FP_SPECIAL_BYPASS_EN
        r = (a[30:23] == 8'h00) || (a[30:23] == 8'hFF) ||
            (b[30:23] == 8'h00) || (b[30:23] == 8'hFF);
`endif
        return r;
    endfunction

    // Behavioural adder: one-cycle ResultValid pulse dly cycles after issue; dly<0 never answers.
    initial begin
        int   cnt;
        bit   pend;
        iss_t e;
        cnt = 0;
        pend = 1'b0;
        AddResultValid = 1'b0;
        AddResult = '0;
        forever begin
            @(negedge Clock);
            AddResultValid = 1'b0;
            if (pend && cnt == 0) begin
                AddResultValid = 1'b1;
                pend = 1'b0;
            end else if (pend) begin
                cnt--;
            end
            if (AddInputValid && Reset) begin
                issue_cnt++;
                checks++;
                if (pend || OutValid || iss_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_issue actual=1 required=0 pend=%0d outvalid=%0d queued=%0d",
                             pend, OutValid, iss_q.size());
                end else begin
                    e = iss_q.pop_front();
                    chk("add_op1", AddOp1, e.a);
                    chk("add_op2", AddOp2, e.b);
                    AddResult = e.ares;
                    pend = (e.dly >= 0);
                    cnt = e.dly;
                end
            end
        end
    end

    always @(negedge Clock) begin
        exp_t e;
        if (Reset && OutValid && OutReady) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result actual=%h required=none", OutResult);
            end else begin
                e = exp_q.pop_front();
                chk("out_result", OutResult, e.res);
                chk("out_error", {31'h0, OutError}, {31'h0, e.err});
            end
        end
    end

    task automatic push_pair(input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] res, input logic err,
                             input int dly, input bit track);
        int g = 0;
        iss_t ie;
        exp_t ee;
        InOp1 = a;
        InOp2 = b;
        InValid = 1'b1;
        while (!InReady && g < 500) begin
            @(posedge Clock); #1;
            g++;
        end
        if (g >= 500) begin
            checks++; errors++;
            $display("FAIL push_timeout actual=InReady_low required=InReady_high");
        end
        if (track) begin
            ee.res = res; ee.err = err;
            exp_q.push_back(ee);
        end
        if (!bypassed(a, b)) begin
            ie.a = a; ie.b = b; ie.ares = res; ie.dly = dly;
            iss_q.push_back(ie);
        end
        @(posedge Clock); #1;
        InValid = 1'b0;
    endtask

    task automatic wait_drain(input int bound);
        int g = 0;
        while ((exp_q.size() != 0 || OutValid) && g < bound) begin
            @(posedge Clock); #1;
            g++;
        end
        if (g >= bound) begin
            checks++; errors++;
            $display("FAIL drain_timeout actual=%0d_pending required=0", exp_q.size());
        end
    endtask

    task automatic wait_outvalid(input string name, input int bound);
        int g = 0;
        while (!OutValid && g < bound) begin
            @(posedge Clock); #1;
            g++;
        end
        if (g >= bound) begin
            checks++; errors++;
            $display("FAIL %s actual=no_outvalid required=outvalid", name);
        end
    endtask

    task automatic wait_issue(input string name, input int bound);
        int g = 0;
        do begin
            @(negedge Clock);
            g++;
        end while (!AddInputValid && g < bound);
        if (!AddInputValid) begin
            checks++; errors++;
            $display("FAIL %s actual=no_issue required=issue", name);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_inready"},   {31'h0, InReady}, 32'h1);
        chk({tag, "_outvalid"},  {31'h0, OutValid}, 32'h0);
        chk({tag, "_addvalid"},  {31'h0, AddInputValid}, 32'h0);
        chk({tag, "_outresult"}, OutResult, 32'h0);
        chk({tag, "_outerror"},  {31'h0, OutError}, 32'h0);
        chk({tag, "_addop1"},    AddOp1, 32'h0);
        chk({tag, "_occupancy"}, {29'h0, Occupancy}, 32'h0);
    endtask

    initial begin
        int ic, n, bad;
        logic [31:0] held;
        logic [31:0] va[6], vb[6], vr[6];

        Reset = 1'b0; InValid = 1'b0; InOp1 = '0; InOp2 = '0; OutReady = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        chk_reset_outputs("reset");
        Reset = 1'b1;
        @(posedge Clock); #1;

        // Single pair, consumer stalls, issue latency and hold stability
        ic = issue_cnt;
        push_pair(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 5, 1'b1);
        chk("issue_not_early", {31'h0, AddInputValid}, 32'h0);
        @(posedge Clock); #1;
        chk("issue_latency", {31'h0, AddInputValid}, 32'h1);
        wait_outvalid("t1_result", 30);
        held = OutResult;
        bad = 0;
        repeat (5) begin
            @(posedge Clock); #1;
            if (!OutValid || OutResult !== held) bad++;
        end
        chk("t1_hold_stable", bad, 0);
        chk("t1_held_value", held, 32'h4040_0000);
        OutReady = 1'b1;
        wait_drain(50);
        chk("t1_issue_count", issue_cnt - ic, 1);

        // Five back-to-back pairs into a four-deep FIFO
        ic = issue_cnt;
        push_pair(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 3, 1'b1);
        push_pair(32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 1'b0, 2, 1'b1);
        push_pair(32'h4080_0000, 32'h3F80_0000, 32'h40A0_0000, 1'b0, 4, 1'b1);
        push_pair(32'h4000_0000, 32'h4080_0000, 32'h40C0_0000, 1'b0, 1, 1'b1);
        push_pair(32'h4040_0000, 32'h4080_0000, 32'h40E0_0000, 1'b0, 3, 1'b1);
        chk("t2_occupancy_full", {29'h0, Occupancy}, 32'd4);
        chk("t2_inready_low", {31'h0, InReady}, 32'h0);
        wait_drain(400);
        chk("t2_issue_count", issue_cnt - ic, 5);

        // Adder never answers: watchdog result, then normal operation
        push_pair(32'h4000_0000, 32'h3F80_0000, 32'h7FC0_0000, 1'b1, -1, 1'b1);
        wait_issue("t3_issue", 20);
        n = 0;
        do begin
            @(negedge Clock);
            n++;
        end while (!OutValid && n < 200);
        chk("t3_timeout_cycles", n, 65);
        wait_drain(20);
        push_pair(32'h4080_0000, 32'h3F80_0000, 32'h40A0_0000, 1'b0, 3, 1'b1);
        wait_drain(50);

        // Consumer stalls with pairs queued behind the held result
        OutReady = 1'b0;
        ic = issue_cnt;
        push_pair(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0, 2, 1'b1);
        push_pair(32'h4080_0000, 32'h4080_0000, 32'h4100_0000, 1'b0, 2, 1'b1);
        push_pair(32'h4040_0000, 32'h4000_0000, 32'h40A0_0000, 1'b0, 2, 1'b1);
        wait_outvalid("t4_result", 30);
        chk("t4_occupancy", {29'h0, Occupancy}, 32'd2);
        held = OutResult;
        bad = 0;
        repeat (20) begin
            @(posedge Clock); #1;
            if (!OutValid || OutResult !== held) bad++;
        end
        chk("t4_hold_stable", bad, 0);
        chk("t4_no_issue_while_held", issue_cnt - ic, 1);
        OutReady = 1'b1;
        wait_drain(200);
        chk("t4_issue_count", issue_cnt - ic, 3);

        // Reset while waiting on the adder; its late answer must be ignored
        push_pair(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 10, 1'b0);
        push_pair(32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 1'b0, 2, 1'b0);
        wait_issue("t5_issue", 20);
        repeat (3) @(posedge Clock);
        #1;
        Reset = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        iss_q.delete();
        @(negedge Clock);
        Reset = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge Clock);
            if (OutValid || AddInputValid) bad++;
        end
        chk("t5_late_edge_ignored", bad, 0);

        // Special operands: local result with the bypass build, adder otherwise
        va[0] = 32'h7F80_0000; vb[0] = 32'hFF80_0000; vr[0] = 32'h7FC0_0000;
        va[1] = 32'h0000_0000; vb[1] = 32'h3F80_0000; vr[1] = 32'h3F80_0000;
        va[2] = 32'h8000_0000; vb[2] = 32'h8000_0000; vr[2] = 32'h8000_0000;
        va[3] = 32'h8000_0000; vb[3] = 32'h0000_0000; vr[3] = 32'h0000_0000;
        va[4] = 32'h7F80_0000; vb[4] = 32'h3F80_0000; vr[4] = 32'h7F80_0000;
        va[5] = 32'h7F80_0001; vb[5] = 32'h3F80_0000; vr[5] = 32'h7FC0_0000;
        ic = issue_cnt;
        for (int i = 0; i < 6; i++) begin
            push_pair(va[i], vb[i], vr[i], 1'b0, 2, 1'b1);
        end
        wait_drain(300);
`ifdef FP_SPECIAL_BYPASS_EN
        chk("t6_issue_count", issue_cnt - ic, 0);
`else
        chk("t6_issue_count", issue_cnt - ic, 6);
`endif
        chk("final_scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
